// File: rtl/bus_cycle_pkg.sv
// Shared T-state encoding, cycle kinds and bus-control payload for the bus cycle sequencer.
package bus_cycle_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned I_W    = 8;
  localparam int unsigned R_W    = 7;
  localparam int unsigned WCNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_TWA  = 3'd4,
    ST_T3   = 3'd5,
    ST_T4   = 3'd6
  } tstate_e;

  typedef enum logic [2:0] {
    CYC_FETCH  = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4
  } cycle_e;

  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic rfsh_n;
    logic d_oe;
    logic read_dtcs;
    logic inc_pc;
    logic inc_r;
    logic busy;
    logic done;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{
    m1_n: 1'b1, mreq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, rfsh_n: 1'b1,
    d_oe: 1'b0, read_dtcs: 1'b0, inc_pc: 1'b0, inc_r: 1'b0, busy: 1'b0, done: 1'b0
  };

  // Last T-state of a cycle: T4 for opcode fetch, T3 for everything else.
  function automatic logic is_final(tstate_e st, cycle_e cyc);
    return (st == ST_T4) || ((st == ST_T3) && (cyc != CYC_FETCH));
  endfunction

endpackage

// File: rtl/bus_cycle_addr.sv
// Address latch: true-polarity bus address at T1, refresh address at fetch T3.
module bus_cycle_addr
  import bus_cycle_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_bus,
  input  logic              ld_rfsh,
  input  logic              fetch,
  input  logic              addr_sel,
  input  logic [ADDR_W-1:0] notPC,
  input  logic [ADDR_W-1:0] notAddr,
  input  logic [I_W-1:0]    notI,
  input  logic [R_W-1:0]    notR,
  output logic [ADDR_W-1:0] A
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      A <= '0;
    end else if (ld_bus) begin
      A <= (fetch || !addr_sel) ? ~notPC : ~notAddr;
    end else if (ld_rfsh) begin
      A <= {~notI, 1'b0, ~notR};
    end
  end

endmodule

// File: rtl/bus_cycle.sv
// Bus cycle sequencer: arbitrates requests and walks T-states, driving registered strobes.
module bus_cycle
  import bus_cycle_pkg::*;
#(
  parameter int unsigned IO_AUTO_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PB_Fetch,
  input  logic              PB_MemRead,
  input  logic              PB_MemWrite,
  input  logic              PB_IORead,
  input  logic              PB_IOWrite,
  input  logic              PB_AddrSel,
  input  logic [ADDR_W-1:0] notPC,
  input  logic [ADDR_W-1:0] notAddr,
  input  logic [I_W-1:0]    notI,
  input  logic [R_W-1:0]    notR,
  input  logic              notWAIT,
  output logic [ADDR_W-1:0] A,
  output logic              notM1,
  output logic              notMREQ,
  output logic              notIORQ,
  output logic              notRD,
  output logic              notWR,
  output logic              notRFSH,
  output logic              D_oe,
  output logic              PI_ReadDtcs,
  output logic              PR_Inc_PC,
  output logic              PR_Inc_R,
  output logic              Busy,
  output logic              Done
);

  tstate_e           state, state_nxt;
  cycle_e            cyc, cyc_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  bus_ctl_t          ctl, ctl_nxt;
  logic              start_c;
  logic              is_io_c;

  // State, cycle kind, auto-wait counter and registered strobes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cyc      <= CYC_FETCH;
      wait_cnt <= '0;
      ctl      <= CTL_IDLE;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      wait_cnt <= wait_cnt_nxt;
      ctl      <= ctl_nxt;
    end
  end

  // Next-state: T-state sequencing plus request arbitration in IDLE or a Done cycle
  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc;
    wait_cnt_nxt = wait_cnt;
    start_c      = 1'b0;
    is_io_c      = (cyc == CYC_IO_RD) || (cyc == CYC_IO_WR);

    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_T1:   state_nxt = ST_T2;
      ST_T2: begin
        if (is_io_c && (IO_AUTO_WAIT != 0)) begin
          state_nxt    = ST_TWA;
          wait_cnt_nxt = WCNT_W'(IO_AUTO_WAIT);
        end else begin
          state_nxt = notWAIT ? ST_T3 : ST_TW;
        end
      end
      ST_TWA: begin
        wait_cnt_nxt = wait_cnt - WCNT_W'(1);
        if (wait_cnt == WCNT_W'(1)) state_nxt = notWAIT ? ST_T3 : ST_TW;
      end
      ST_TW:   state_nxt = notWAIT ? ST_T3 : ST_TW;
      ST_T3:   state_nxt = (cyc == CYC_FETCH) ? ST_T4 : ST_IDLE;
      ST_T4:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if ((state == ST_IDLE) || is_final(state, cyc)) begin
      start_c = PB_Fetch | PB_MemRead | PB_MemWrite | PB_IORead | PB_IOWrite;
      if (PB_Fetch)         cyc_nxt = CYC_FETCH;
      else if (PB_MemRead)  cyc_nxt = CYC_MEM_RD;
      else if (PB_MemWrite) cyc_nxt = CYC_MEM_WR;
      else if (PB_IORead)   cyc_nxt = CYC_IO_RD;
      else if (PB_IOWrite)  cyc_nxt = CYC_IO_WR;
      if (start_c) state_nxt = ST_T1;
    end
  end

  // Strobe decode of the upcoming T-state, registered so every strobe is glitch-free
  always_comb begin
    ctl_nxt = CTL_IDLE;
    case (state_nxt)
      ST_T1, ST_T2, ST_TWA, ST_TW: begin
        ctl_nxt.busy = 1'b1;
        case (cyc_nxt)
          CYC_FETCH: begin
            ctl_nxt.m1_n   = 1'b0;
            ctl_nxt.mreq_n = 1'b0;
            ctl_nxt.rd_n   = 1'b0;
          end
          CYC_MEM_RD: begin
            ctl_nxt.mreq_n = 1'b0;
            ctl_nxt.rd_n   = 1'b0;
          end
          CYC_MEM_WR: begin
            ctl_nxt.mreq_n = 1'b0;
            ctl_nxt.wr_n   = (state_nxt == ST_T1);
            ctl_nxt.d_oe   = 1'b1;
          end
          CYC_IO_RD: begin
            ctl_nxt.iorq_n = (state_nxt == ST_T1);
            ctl_nxt.rd_n   = (state_nxt == ST_T1);
          end
          CYC_IO_WR: begin
            ctl_nxt.iorq_n = (state_nxt == ST_T1);
            ctl_nxt.wr_n   = (state_nxt == ST_T1);
            ctl_nxt.d_oe   = 1'b1;
          end
          default: ctl_nxt.busy = 1'b1;
        endcase
      end
      ST_T3: begin
        ctl_nxt.busy = 1'b1;
        case (cyc_nxt)
          CYC_FETCH: begin
            ctl_nxt.mreq_n    = 1'b0;
            ctl_nxt.rfsh_n    = 1'b0;
            ctl_nxt.read_dtcs = 1'b1;
            ctl_nxt.inc_pc    = 1'b1;
          end
          CYC_MEM_WR: begin
            ctl_nxt.mreq_n = 1'b0;
            ctl_nxt.d_oe   = 1'b1;
            ctl_nxt.done   = 1'b1;
          end
          CYC_IO_WR: begin
            ctl_nxt.d_oe = 1'b1;
            ctl_nxt.done = 1'b1;
          end
          default: begin
            ctl_nxt.read_dtcs = 1'b1;
            ctl_nxt.done      = 1'b1;
          end
        endcase
      end
      ST_T4: begin
        ctl_nxt.busy   = 1'b1;
        ctl_nxt.mreq_n = 1'b0;
        ctl_nxt.rfsh_n = 1'b0;
        ctl_nxt.inc_r  = 1'b1;
        ctl_nxt.done   = 1'b1;
      end
      default: ctl_nxt = CTL_IDLE;
    endcase
  end

  bus_cycle_addr u_addr (
    .Clk      (Clk),
    .Reset    (Reset),
    .ld_bus   (start_c),
    .ld_rfsh  ((state_nxt == ST_T3) && (cyc_nxt == CYC_FETCH)),
    .fetch    (cyc_nxt == CYC_FETCH),
    .addr_sel (PB_AddrSel),
    .notPC    (notPC),
    .notAddr  (notAddr),
    .notI     (notI),
    .notR     (notR),
    .A        (A)
  );

  assign notM1       = ctl.m1_n;
  assign notMREQ     = ctl.mreq_n;
  assign notIORQ     = ctl.iorq_n;
  assign notRD       = ctl.rd_n;
  assign notWR       = ctl.wr_n;
  assign notRFSH     = ctl.rfsh_n;
  assign D_oe        = ctl.d_oe;
  assign PI_ReadDtcs = ctl.read_dtcs;
  assign PR_Inc_PC   = ctl.inc_pc;
  assign PR_Inc_R    = ctl.inc_r;
  assign Busy        = ctl.busy;
  assign Done        = ctl.done;

endmodule
